fb_scanout: RTL
===============

# fb_scanout

Video scan-out stage directly downstream of the SDRAM framebuffer stream port. Generates VGA-style raster timing, drives the framebuffer's frame-start and stream-enable strobes, scales the FB_WIDTH×FB_HEIGHT image by an integer factor, and emits registered 4:4:4 RGB with sync and data-enable. A line buffer replays each fetched line for vertical scaling, so the stream is read exactly once per frame.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48: porch and sync widths in pixels
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33: porch and sync widths in lines
- FB_WIDTH, 320; FB_HEIGHT, 240: source image size in words
- SCALE, 2: integer pixel/line replication factor, ≥1; FB_WIDTH*SCALE ≤ H_ACTIVE, FB_HEIGHT*SCALE ≤ V_ACTIVE
- BORDER_COLOR, 12'h000: RGB444 shown outside the image area or when disabled

Ports (one clock `clk_pix`; reset `reset_n_i` asynchronous, active-low):
- clk_pix  in  1  pixel clock
- reset_n_i  in  1  asynchronous active-low reset
- enable_i  in  1  scan-out enable, sampled at frame boundary
- stream_start_frame_o  out  1  one-cycle frame-start strobe to framebuffer
- stream_ena_o  out  1  advance stream by one word
- stream_data_i  in  16  current stream word, ARGB4444 (bits 15:12 ignored)
- stream_preloading_i  in  1  framebuffer preload in progress
- stream_err_underflow_i  in  1  framebuffer underflow pulse
- vga_hsync_o, vga_vsync_o  out  1 each  negative-polarity sync
- vga_de_o  out  1  visible-area data enable
- vga_r_o, vga_g_o, vga_b_o  out  4 each  colour
- err_count_o  out  16  error counter (see Configuration)

## Operation
- Counters h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1 (H_TOTAL = sum of H params, same for V); h wraps and increments v; v wraps to 0.
- Visible: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. Image area: h_cnt<FB_WIDTH*SCALE && v_cnt<FB_HEIGHT*SCALE, top-left aligned.
- Sub-counters x_sub, y_sub 0..SCALE-1; fb_x 0..FB_WIDTH-1 advances when x_sub wraps. Line is "fresh" when y_sub==0.
- Frame-enable register run latched from enable_i at h_cnt==H_TOTAL-1, v_cnt==V_TOTAL-1 only.
- stream_start_frame_o: combinational decode, high for the cycle h_cnt==0, v_cnt==V_ACTIVE, when run=1.
- stream_ena_o: combinational, high when run && image area && fresh && x_sub==SCALE-1. Exactly FB_WIDTH×FB_HEIGHT strobes per frame.
- Fresh lines: at x_sub==0 sample stream_data_i into pixel register and write it to line buffer[fb_x]. Repeat lines: synchronous read of line buffer[fb_x] at x_sub==0, held SCALE cycles.
- Line buffer: FB_WIDTH×12 bits, single write port, single synchronous read port.
- Colour: image area && run → pixel (fresh) or buffer data (repeat); visible otherwise → BORDER_COLOR; non-visible → 0.
- hsync low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync analogously on v_cnt.

## Timing
- All vga_* outputs registered; one cycle latency from the counter value they decode. stream_* strobes are not delayed.
- stream_data_i is sampled in the cycle where x_sub==0. The framebuffer holds each word until the stream_ena_o cycle, so the sampled word is the current word.
- Reset: counters, sub-counters, run, err_count_o = 0; vga_hsync_o = vga_vsync_o = 1; vga_de_o, rgb, stream_start_frame_o, stream_ena_o = 0.
- Reset mid-frame: outputs return to reset values immediately. The next start strobe occurs at v_cnt==V_ACTIVE after reset release, so the first partial frame shows border only (run=0).
- enable_i toggling mid-frame has no effect until the frame boundary.
- start_frame and stream_ena can never coincide, because start falls in vertical blanking.

## Configuration
- FB_SCANOUT_ERR_COUNT_EN defined: err_count_o is a 16-bit saturating counter (stops at 16'hFFFF), cleared only by reset. It increments by 1 on each stream_err_underflow_i cycle. It also increments by 1 when stream_preloading_i=1 at h_cnt==0, v_cnt==0 with run=1. If both events occur in the same cycle, it still increments by only 1.
- Undefined: err_count_o tied to 16'd0; inputs unused.

## Test plan
- Tiny timing (H 8/1/1/1, V 4/1/1/1, FB 4×2, SCALE 2), reset release, enable_i=1 → hsync period 11 clocks low 1; vsync period 7 lines; de high 8 per visible line.
- Same config, stream supplies words 0x0ABC, 0x0DEF… → each colour is held 2 clocks; line 1 repeats line 0; 8 stream_ena_o pulses per frame; one start strobe at v_cnt==4.
- enable_i dropped mid-frame → remainder of frame unchanged; next frame shows BORDER_COLOR with no stream_ena_o and no start strobe.
- stream_preloading_i held high across v_cnt==0 start, with macro → err_count_o=1; 3 underflow pulses → 4.
- Without macro: same stimulus → err_count_o stays 0.
- reset_n_i asserted mid-line asynchronously → hsync/vsync=1, de=0, rgb=0 before the next clock edge; the first start strobe after release occurs at v_cnt==V_ACTIVE.

Source files
------------

// File: rtl/fb_scanout.sv
// fb_scanout: raster timing, framebuffer stream strobes, integer scaling with line-buffer replay.
// Latency: vga_* outputs register the current counter decode (1 cycle); stream_* strobes are combinational.
// Optional: define FB_SCANOUT_ERR_COUNT_EN for the saturating underflow/late-preload error counter.
module fb_scanout #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          FB_WIDTH     = 320,
  parameter int          FB_HEIGHT    = 240,
  parameter int          SCALE        = 2,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input  logic        clk_pix,
  input  logic        reset_n_i,
  input  logic        enable_i,
  output logic        stream_start_frame_o,
  output logic        stream_ena_o,
  input  logic [15:0] stream_data_i,
  input  logic        stream_preloading_i,
  input  logic        stream_err_underflow_i,
  output logic        vga_hsync_o,
  output logic        vga_vsync_o,
  output logic        vga_de_o,
  output logic [3:0]  vga_r_o,
  output logic [3:0]  vga_g_o,
  output logic [3:0]  vga_b_o,
  output logic [15:0] err_count_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;

  // Back porches are assumed non-zero so the sync end values fit the counter widths.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] IMG_W_L  = HW'(FB_WIDTH * SCALE);
  localparam logic [VW-1:0] IMG_H_L  = VW'(FB_HEIGHT * SCALE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [SW-1:0] r_x_sub;
  logic [SW-1:0] r_y_sub;
  logic [XW-1:0] r_fb_x;
  logic          r_run;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [11:0]   r_rgb;
  logic [11:0]   r_line_buf [FB_WIDTH];

  logic          w_h_last;
  logic          w_v_last;
  logic          w_visible;
  logic          w_img_h;
  logic          w_img;
  logic          w_fresh;
  logic          w_x_first;
  logic [11:0]   w_src;

  assign w_h_last  = (r_h_cnt == H_LAST);
  assign w_v_last  = (r_v_cnt == V_LAST);
  assign w_visible = (r_h_cnt < H_ACT_L) && (r_v_cnt < V_ACT_L);
  assign w_img_h   = (r_h_cnt < IMG_W_L);
  assign w_img     = w_img_h && (r_v_cnt < IMG_H_L);
  assign w_fresh   = (r_y_sub == '0);
  assign w_x_first = (r_x_sub == '0);

  // Fresh lines take the live stream word; repeat lines replay the word stored on the fresh line.
  assign w_src = w_fresh ? stream_data_i[11:0] : r_line_buf[r_fb_x];

  // Start strobe sits in vertical blanking, so it can never overlap a stream advance.
  assign stream_start_frame_o = r_run && (r_h_cnt == '0) && (r_v_cnt == V_ACT_L);
  assign stream_ena_o         = r_run && w_img && w_fresh && (r_x_sub == SUB_LAST);

  // Raster position: h wraps each line and carries into v.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Horizontal replication: x_sub counts SCALE clocks per source word, fb_x indexes the word.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_x_sub <= '0;
      r_fb_x  <= '0;
    end else if (w_h_last) begin
      r_x_sub <= '0;
      r_fb_x  <= '0;
    end else if (w_img_h) begin
      if (r_x_sub == SUB_LAST) begin
        r_x_sub <= '0;
        r_fb_x  <= r_fb_x + 1'b1;
      end else begin
        r_x_sub <= r_x_sub + 1'b1;
      end
    end
  end

  // Vertical replication: y_sub==0 marks the line that consumes the stream.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_y_sub <= '0;
    end else if (w_h_last) begin
      if (w_v_last) begin
        r_y_sub <= '0;
      end else if (r_v_cnt < IMG_H_L) begin
        r_y_sub <= (r_y_sub == SUB_LAST) ? '0 : r_y_sub + 1'b1;
      end
    end
  end

  // Enable only takes effect at the frame boundary so a frame is never cut short.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_run <= 1'b0;
    end else if (w_h_last && w_v_last) begin
      r_run <= enable_i;
    end
  end

  // Line buffer write: capture each fresh-line word for replay on the following lines.
  always_ff @(posedge clk_pix) begin
    if (r_run && w_img && w_fresh && w_x_first) begin
      r_line_buf[r_fb_x] <= stream_data_i[11:0];
    end
  end

  // Registered video outputs; the colour register doubles as the held pixel within a scaled word.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_hsync <= !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
      r_vsync <= !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
      r_de    <= w_visible;
      if (w_img && r_run) begin
        if (w_x_first) begin
          r_rgb <= w_src;
        end
      end else if (w_visible) begin
        r_rgb <= BORDER_COLOR;
      end else begin
        r_rgb <= '0;
      end
    end
  end

  assign vga_hsync_o = r_hsync;
  assign vga_vsync_o = r_vsync;
  assign vga_de_o    = r_de;
  assign vga_r_o     = r_rgb[11:8];
  assign vga_g_o     = r_rgb[7:4];
  assign vga_b_o     = r_rgb[3:0];

`ifdef FB_SCANOUT_ERR_COUNT_EN
  logic [15:0] r_err_count;
  logic        w_err_evt;

  // Underflow and a preload still running at the top of a live frame are one event per cycle.
  assign w_err_evt = stream_err_underflow_i ||
                     (stream_preloading_i && r_run && (r_h_cnt == '0) && (r_v_cnt == '0));

  // Saturating error count, cleared only by reset.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err_count <= '0;
    end else if (w_err_evt && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count_o = r_err_count;

  logic w_unused;
  assign w_unused = ^stream_data_i[15:12];
`else
  assign err_count_o = 16'd0;

  logic w_unused;
  assign w_unused = ^{stream_data_i[15:12], stream_preloading_i, stream_err_underflow_i};
`endif

endmodule
